// File: rtl/transmit_sequencer.sv
// Programmable step sequencer: stores {dwell, select} beats and replays them onto the channel-mux
// configuration stream, once or continuously, with a one-cycle trigger after each accepted step.
module transmit_sequencer #(
   parameter int CHANNELS    = 8,
   parameter int SEL_WIDTH   = $clog2(3*CHANNELS),
   parameter int DEPTH       = 16,
   parameter int DWELL_WIDTH = 32
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [DWELL_WIDTH+CHANNELS*SEL_WIDTH-1:0] prog_in_data,
   input  logic                                     prog_in_valid,
   input  logic                                     prog_in_last,
   output logic                                     prog_in_ready,
   input  logic [1:0]                               start_stop_data,
   input  logic                                     start_stop_valid,
   output logic                                     start_stop_ready,
   output logic [CHANNELS*SEL_WIDTH-1:0]            mux_config_data,
   output logic                                     mux_config_valid,
   input  logic                                     mux_config_ready,
   output logic                                     step_trigger,
   output logic                                     busy,
   output logic [$clog2(DEPTH)-1:0]                 step_index,
   output logic                                     prog_overflow
);

   localparam int SELW  = CHANNELS * SEL_WIDTH;
   localparam int BEATW = DWELL_WIDTH + SELW;
   localparam int AW    = $clog2(DEPTH);
   localparam int LW    = AW + 1;

   typedef enum logic [1:0] {IDLE, FETCH, SEND, DWELL} state_t;

   state_t                 state, next_state;
   logic [BEATW-1:0]       mem [DEPTH];
   logic [LW-1:0]          wr_addr, prog_len;
   logic                   first_beat, wr_room, prog_fire;
   logic [AW-1:0]          rd_addr;
   logic [DWELL_WIDTH-1:0] dwell_q, cnt;
   logic [SELW-1:0]        sel_q;
   logic                   loop_mode, stop_pending;
   logic                   start_cmd, stop_cmd, start_accept, mux_fire, last_step, dwell_done;

   // reset is active-low, so the loader is only ready once reset is released and the sequencer is idle
   assign prog_in_ready    = reset && (state == IDLE);
   assign start_stop_ready = 1'b1;
   assign mux_config_valid = (state == SEND);
   assign mux_config_data  = sel_q;
   assign busy             = (state != IDLE);

   assign prog_fire    = prog_in_valid && prog_in_ready;
   assign wr_room      = (wr_addr < LW'(DEPTH));
   assign start_cmd    = start_stop_valid && start_stop_data[0];
   assign stop_cmd     = start_stop_valid && (start_stop_data == 2'b00);
   assign start_accept = (state == IDLE) && start_cmd && (prog_len != '0);
   assign mux_fire     = mux_config_valid && mux_config_ready;
   assign last_step    = (LW'(rd_addr) == prog_len - LW'(1));
   assign dwell_done   = (cnt == DWELL_WIDTH'(1));

   // NOTE: the program store has no reset; prog_len alone decides which entries replay may read.
   always_ff @(posedge clk) begin
      if (prog_fire && wr_room) mem[wr_addr[AW-1:0]] <= prog_in_data;
   end

   // Beats past DEPTH are dropped and flagged; the flag survives until the next packet begins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_addr       <= '0;
         prog_len      <= '0;
         first_beat    <= 1'b1;
         prog_overflow <= 1'b0;
      end else if (prog_fire) begin
         first_beat    <= prog_in_last;
         prog_overflow <= (prog_overflow && !first_beat) || !wr_room;
         if (prog_in_last) begin
            wr_addr  <= '0;
            prog_len <= wr_room ? wr_addr + LW'(1) : wr_addr;
         end else if (wr_room) begin
            wr_addr <= wr_addr + LW'(1);
         end
      end
   end

   // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: next_state takes its default before the case so no path can infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start_accept) next_state = FETCH;
         FETCH:   next_state = stop_cmd ? IDLE : SEND;
         SEND:    if (mux_fire) next_state = (stop_pending || stop_cmd) ? IDLE : DWELL;
         DWELL: begin
            if (stop_cmd)        next_state = IDLE;
            else if (dwell_done) next_state = (last_step && !loop_mode) ? IDLE : FETCH;
         end
         default: next_state = IDLE;
      endcase
   end

   // sel_q doubles as the memory read register, so the mux word holds between steps.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_addr      <= '0;
         loop_mode    <= 1'b0;
         stop_pending <= 1'b0;
         dwell_q      <= '0;
         sel_q        <= '0;
         cnt          <= '0;
         step_index   <= '0;
         step_trigger <= 1'b0;
      end else begin
         step_trigger <= mux_fire;
         case (state)
            IDLE: begin
               if (start_accept) begin
                  rd_addr   <= '0;
                  loop_mode <= start_stop_data[1];
               end
            end
            FETCH: begin
               if (!stop_cmd) {dwell_q, sel_q} <= mem[rd_addr];
            end
            SEND: begin
               if (stop_cmd) stop_pending <= 1'b1;
               if (mux_fire) begin
                  step_index <= rd_addr;
                  cnt        <= (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
               end
            end
            DWELL: begin
               if (!stop_cmd) begin
                  if (dwell_done) rd_addr <= last_step ? '0 : rd_addr + AW'(1);
                  else            cnt     <= cnt - DWELL_WIDTH'(1);
               end
            end
            default: ;
         endcase
         if (next_state == IDLE) stop_pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_transmit_sequencer.sv
// Self-checking bench for transmit_sequencer: a timestamp-based reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized programs, commands and backpressure.
module tb_transmit_sequencer;

   localparam int CHANNELS    = 8;
   localparam int SEL_WIDTH   = $clog2(3*CHANNELS);
   localparam int DEPTH       = 16;
   localparam int DWELL_WIDTH = 32;
   localparam int SELW        = CHANNELS * SEL_WIDTH;
   localparam int BEATW       = DWELL_WIDTH + SELW;
   localparam int AW          = $clog2(DEPTH);

   logic             clk   = 1'b0;
   logic             reset = 1'b0;
   logic [BEATW-1:0] pdata = '0;
   logic             pv    = 1'b0;
   logic             plast = 1'b0;
   logic             pready;
   logic [1:0]       ssd   = 2'b10;
   logic             ssv   = 1'b0;
   logic             ss_ready;
   logic [SELW-1:0]  mux_config_data;
   logic             mux_config_valid;
   logic             mux_ready = 1'b0;
   logic             step_trigger, busy, prog_overflow;
   logic [AW-1:0]    step_index;

   transmit_sequencer #(
      .CHANNELS(CHANNELS), .SEL_WIDTH(SEL_WIDTH), .DEPTH(DEPTH), .DWELL_WIDTH(DWELL_WIDTH)
   ) dut (
      .clk(clk), .reset(reset),
      .prog_in_data(pdata), .prog_in_valid(pv), .prog_in_last(plast), .prog_in_ready(pready),
      .start_stop_data(ssd), .start_stop_valid(ssv), .start_stop_ready(ss_ready),
      .mux_config_data(mux_config_data), .mux_config_valid(mux_config_valid),
      .mux_config_ready(mux_ready),
      .step_trigger(step_trigger), .busy(busy), .step_index(step_index),
      .prog_overflow(prog_overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: tracks when the next select must appear and when the run ends, by timestamps.
   bit                     m_running, m_loop, m_stop_req, m_first, m_stopc, m_startc;
   int                     m_step, m_len, m_wr;
   longint                 m_tvalid, m_tend, m_d, m_n;
   logic [SELW-1:0]        m_sel   [DEPTH];
   logic [DWELL_WIDTH-1:0] m_dwell [DEPTH];
   logic                   e_valid, e_trig, e_busy, e_ovf;
   logic [SELW-1:0]        e_data;
   int                     e_index;

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         m_running = 0; m_stop_req = 0; m_len = 0; m_wr = 0; m_first = 1;
         m_tvalid = 0; m_tend = -1; m_step = 0;
         e_valid = 0; e_data = '0; e_trig = 0; e_busy = 0; e_index = 0; e_ovf = 0;
      end else begin
         m_n = cyc;
         if (pv && !e_busy) begin
            if (m_first) e_ovf = 0;
            m_first = 0;
            if (m_wr < DEPTH) begin
               m_dwell[m_wr] = pdata[BEATW-1:SELW];
               m_sel[m_wr]   = pdata[SELW-1:0];
               m_wr++;
            end else begin
               e_ovf = 1;
            end
            if (plast) begin
               m_len = m_wr; m_wr = 0; m_first = 1;
            end
         end
         e_trig   = 0;
         m_stopc  = ssv && (ssd == 2'b00);
         m_startc = ssv && ssd[0];
         if (m_running) begin
            if (e_valid) begin
               if (m_stopc) m_stop_req = 1;
               if (mux_ready) begin
                  e_trig  = 1;
                  e_index = m_step;
                  m_d = (m_dwell[m_step] == 0) ? 1 : longint'(m_dwell[m_step]);
                  if (m_stop_req) m_running = 0;
                  else if (m_step == m_len - 1 && !m_loop) begin
                     m_tend   = m_n + m_d + 1;
                     m_tvalid = 64'h7fff_ffff_ffff;
                  end else begin
                     m_tvalid = m_n + m_d + 2;
                     m_step   = (m_step + 1) % m_len;
                  end
               end
            end else if (m_stopc) begin
               m_running = 0;
            end
            if (m_tend == m_n + 1) m_running = 0;
         end else if (m_startc && m_len != 0) begin
            m_running = 1; m_loop = ssd[1]; m_step = 0; m_stop_req = 0;
            m_tvalid = m_n + 2; m_tend = -1;
         end
         e_busy  = m_running;
         e_valid = m_running && (m_n + 1 >= m_tvalid);
         if (e_valid) e_data = m_sel[m_step];
      end
   end

   bit              cmp_en   = 0;
   int              trig_cnt = 0;
   logic [SELW-1:0] hs_q[$];

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("mux_valid", mux_config_valid, e_valid);
         check("mux_data", mux_config_data, e_data);
         check("step_trigger", step_trigger, e_trig);
         check("busy", busy, e_busy);
         check("step_index", step_index, e_index);
         check("prog_overflow", prog_overflow, e_ovf);
         check("prog_ready", pready, reset && !e_busy);
         check("ss_ready", ss_ready, 1'b1);
      end
      if (step_trigger) trig_cnt++;
      if (mux_config_valid && mux_ready) hs_q.push_back(mux_config_data);
   end

   bit rdy_rand = 0;
   initial forever begin
      @(posedge clk);
      #2;
      if (rdy_rand) mux_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_to(input int c);
      int g = 0;
      while (cyc < c && g < 1000) begin
         tick();
         g++;
      end
   endtask

   task automatic cmd(input logic [1:0] d, output int t);
      t   = cyc;
      ssv = 1'b1;
      ssd = d;
      tick();
      ssv = 1'b0;
   endtask

   task automatic load_beat(input logic [DWELL_WIDTH-1:0] dw, input logic [SELW-1:0] sel, input bit last);
      int g = 0;
      pv = 1'b1; pdata = {dw, sel}; plast = last;
      while (!pready && g < 200) begin
         tick();
         g++;
      end
      if (!pready) check("prog_ready_timeout", pready, 1'b1);
      tick();
      pv = 1'b0; plast = 1'b0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 3000) begin
         tick();
         g++;
      end
      check("idle_timeout", busy, 1'b0);
   endtask

   task automatic load_a();
      load_beat(4, 1, 0);
      load_beat(0, 2, 0);
      load_beat(10, 3, 1);
   endtask

   initial begin
      int t, td, g, base_trig, base_hs, n;
      logic [63:0] r;

      tick();
      cmp_en = 1;
      tick();
      check("rst_valid", mux_config_valid, 0);
      check("rst_data", mux_config_data, 0);
      check("rst_trigger", step_trigger, 0);
      check("rst_busy", busy, 0);
      check("rst_index", step_index, 0);
      check("rst_overflow", prog_overflow, 0);
      check("rst_prog_ready", pready, 0);
      reset = 1'b1;
      tick();
      check("prog_ready_after_rst", pready, 1);

      // start with an empty program is ignored
      cmd(2'b01, t);
      check("empty_start_busy", busy, 0);
      wait_to(t + 2);
      check("empty_start_valid", mux_config_valid, 0);

      // single pass of a three-step program, with ignored commands mid-run
      load_a();
      mux_ready = 1'b1;
      base_trig = trig_cnt;
      cmd(2'b01, t);
      check("single_busy_rise", busy, 1);
      check("single_prog_ready_low", pready, 0);
      check("single_fetch_novalid", mux_config_valid, 0);
      wait_to(t + 2);
      check("single_step0_valid", mux_config_valid, 1);
      check("single_step0_data", mux_config_data, 1);
      wait_to(t + 3);
      check("single_step0_trig", step_trigger, 1);
      cmd(2'b11, td);
      cmd(2'b10, td);
      wait_to(t + 8);
      check("single_step1_valid", mux_config_valid, 1);
      check("single_step1_data", mux_config_data, 2);
      wait_to(t + 11);
      check("single_step2_valid", mux_config_valid, 1);
      check("single_step2_data", mux_config_data, 3);
      wait_to(t + 21);
      check("single_busy_last_dwell", busy, 1);
      wait_to(t + 22);
      check("single_busy_fall", busy, 0);
      check("single_last_index", step_index, 2);
      check("single_trigger_count", trig_cnt - base_trig, 3);

      // continuous replay, stopped during DWELL after two full passes
      base_trig = trig_cnt;
      base_hs   = hs_q.size();
      cmd(2'b11, t);
      g = 0;
      while (trig_cnt < base_trig + 6 && g < 300) begin
         tick();
         g++;
      end
      check("loop_two_passes", trig_cnt - base_trig, 6);
      check("loop_still_busy", busy, 1);
      cmd(2'b00, t);
      check("loop_stop_idle", busy, 0);
      repeat (25) tick();
      check("loop_no_more_steps", hs_q.size() - base_hs, 6);
      if (hs_q.size() >= base_hs + 6)
         for (int i = 0; i < 6; i++) check("loop_order", hs_q[base_hs + i], (i % 3) + 1);

      // stop while SEND is stalled by backpressure
      mux_ready = 1'b0;
      base_trig = trig_cnt;
      base_hs   = hs_q.size();
      cmd(2'b01, t);
      for (int c = t + 2; c <= t + 8; c++) begin
         wait_to(c);
         check("stall_valid_held", mux_config_valid, 1);
         check("stall_data_stable", mux_config_data, 1);
         ssd = 2'b00;
         ssv = (c == t + 4);
      end
      wait_to(t + 9);
      ssv = 1'b0;
      mux_ready = 1'b1;
      wait_to(t + 10);
      check("stall_trig", step_trigger, 1);
      check("stall_idle", busy, 0);
      check("stall_valid_drop", mux_config_valid, 0);
      wait_to(t + 11);
      check("stall_trig_single", step_trigger, 0);
      repeat (10) tick();
      check("stall_one_trigger", trig_cnt - base_trig, 1);
      check("stall_one_handshake", hs_q.size() - base_hs, 1);

      // overflow: 20 beats into a 16-entry store
      for (int i = 0; i < 20; i++) begin
         load_beat(i % 3, i + 1, i == 19);
         if (i == 15) check("ovf_at_16", prog_overflow, 0);
         if (i == 16) check("ovf_at_17", prog_overflow, 1);
      end
      check("ovf_sticky", prog_overflow, 1);
      base_trig = trig_cnt;
      cmd(2'b01, t);
      wait_idle();
      check("full_step_count", trig_cnt - base_trig, 16);
      check("full_last_index", step_index, 15);
      check("full_last_data", hs_q[hs_q.size() - 1], 16);
      load_beat(4, 1, 0);
      check("ovf_cleared", prog_overflow, 0);
      load_beat(0, 2, 0);
      load_beat(10, 3, 1);

      // reset mid-run clears everything, including the program length
      cmd(2'b01, t);
      wait_to(t + 9);
      reset = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", mux_config_valid, 0);
      check("midrst_data", mux_config_data, 0);
      check("midrst_trigger", step_trigger, 0);
      check("midrst_index", step_index, 0);
      check("midrst_overflow", prog_overflow, 0);
      check("midrst_prog_ready", pready, 0);
      tick();
      tick();
      reset = 1'b1;
      cmd(2'b01, t);
      check("midrst_start_ignored", busy, 0);
      wait_to(t + 2);
      check("midrst_no_valid", mux_config_valid, 0);

      // randomized programs, commands, backpressure and occasional resets
      rdy_rand = 1;
      for (int it = 0; it < 40; it++) begin
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) begin
            r = {$urandom, $urandom};
            load_beat(DWELL_WIDTH'($urandom_range(0, 5)), r[SELW-1:0], i == n - 1);
         end
         cmd(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01, td);
         repeat ($urandom_range(5, 50)) begin
            case ($urandom_range(0, 15))
               0: cmd(2'b00, td);
               1: cmd(2'b10, td);
               2: cmd(2'b11, td);
               3: cmd(2'b01, td);
               4: begin
                  if (it % 7 == 3) begin
                     reset = 1'b0;
                     tick();
                     reset = 1'b1;
                  end else begin
                     tick();
                  end
               end
               default: tick();
            endcase
         end
         cmd(2'b00, td);
         wait_idle();
      end
      rdy_rand = 0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
